// File: rtl/speed_stepper_pkg.sv
// Shared types and coil-pattern tables for the stepper phase sequencer.
// Phase states are encoded 0..7 so the low three bits index the pattern table directly.
package speed_stepper_pkg;

  typedef enum logic [3:0] {
    ST_PH0  = 4'd0,
    ST_PH1  = 4'd1,
    ST_PH2  = 4'd2,
    ST_PH3  = 4'd3,
    ST_PH4  = 4'd4,
    ST_PH5  = 4'd5,
    ST_PH6  = 4'd6,
    ST_PH7  = 4'd7,
    ST_IDLE = 4'd8
  } state_e;

  localparam logic [3:0] COIL_IDLE = 4'b0000;

  // Half-step sequence as {sem3,sem2,sem1,sem0}; the wave-drive patterns are its even entries.
  localparam logic [3:0] COIL_TABLE [0:7] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

  function automatic logic [3:0] coil_pattern(input state_e s, input logic half);
    logic [3:0] sv;
    sv = s;
    if (s == ST_IDLE) return COIL_IDLE;
    if (half) return COIL_TABLE[sv[2:0]];
    return COIL_TABLE[{sv[1:0], 1'b0}];
  endfunction

endpackage

// File: rtl/speed_stepper_fsm_step_edge_sync.sv
// Brings the asynchronous step clock into the clk domain and emits a one-cycle pulse per rising edge.
// Flops reset to all-ones so a step clock held high across reset release never produces a step.
module step_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic step_clk_i,
  output logic step_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      delay_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], step_clk_i};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step_pulse_o = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/speed_stepper_fsm.sv
// Unipolar stepper phase sequencer: each synchronised step_clk rise moves one phase in the chosen direction.
// Coil enables are registered alongside the state so they never glitch.
module speed_stepper_fsm
  import speed_stepper_pkg::*;
#(
  parameter int HALF_STEP   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic step_clk,
  input  logic direction,
  output logic sem0,
  output logic sem1,
  output logic sem2,
  output logic sem3
);

  localparam logic       HALF       = (HALF_STEP != 0);
  localparam logic [2:0] LAST_PHASE = HALF ? 3'd7 : 3'd3;

  logic       step_pulse;
  state_e     state_q, state_d;
  logic [3:0] coil_q;
  logic [3:0] coil_d;
  logic [2:0] idx;
  logic [2:0] idx_nxt;

  step_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .step_clk_i   (step_clk),
    .step_pulse_o (step_pulse)
  );

  always_comb begin
    logic [3:0] sv;
    sv      = state_q;
    idx     = sv[2:0];
    idx_nxt = idx;
    state_d = state_q;
    if (step_pulse) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_PH0;
      end else begin
        if (!direction) idx_nxt = (idx == LAST_PHASE) ? 3'd0 : idx + 3'd1;
        else            idx_nxt = (idx == 3'd0) ? LAST_PHASE : idx - 3'd1;
        state_d = state_e'({1'b0, idx_nxt});
      end
    end
    coil_d = coil_pattern(state_d, HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      coil_q  <= COIL_IDLE;
    end else begin
      state_q <= state_d;
      coil_q  <= coil_d;
    end
  end

  assign {sem3, sem2, sem1, sem0} = coil_q;

endmodule

// File: tb/tb_speed_stepper_fsm.sv
// Bench for speed_stepper_fsm: wave-drive and half-step instances share stimulus; a monitor
// pops expected coil patterns from per-instance queues whenever an output changes.
module tb_speed_stepper_fsm;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_clk = 1'b0;
  logic direction = 1'b0;
  always #25 clk = ~clk;

  logic w0, w1, w2, w3, h0, h1, h2, h3;
  logic [3:0] sem_w, sem_h;
  assign sem_w = {w3, w2, w1, w0};
  assign sem_h = {h3, h2, h1, h0};

  speed_stepper_fsm #(.HALF_STEP(0), .SYNC_STAGES(2)) dut_w (
    .clk(clk), .rst(rst), .step_clk(step_clk), .direction(direction),
    .sem0(w0), .sem1(w1), .sem2(w2), .sem3(w3)
  );

  speed_stepper_fsm #(.HALF_STEP(1), .SYNC_STAGES(2)) dut_h (
    .clk(clk), .rst(rst), .step_clk(step_clk), .direction(direction),
    .sem0(h0), .sem1(h1), .sem2(h2), .sem3(h3)
  );

  // reference model: phase position per drive mode, -1 means idle
  logic [3:0] wave_pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] half_pat [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0100, 4'b1100, 4'b1000, 4'b1001};
  int ph_w = -1;
  int ph_h = -1;

  logic [3:0] exp_q_w[$];
  logic [3:0] exp_q_h[$];

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev_w, prev_h;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_phase(input int ph, input int n, input logic dir);
    if (ph < 0) return 0;
    if (!dir) return (ph + 1) % n;
    return (ph + n - 1) % n;
  endfunction

  // driver tasks
  task automatic do_rise(input int high);
    @(negedge clk);
    step_clk = 1'b1;
    ph_w = next_phase(ph_w, 4, direction);
    ph_h = next_phase(ph_h, 8, direction);
    exp_q_w.push_back(wave_pat[ph_w]);
    exp_q_h.push_back(half_pat[ph_h]);
    repeat (high) @(negedge clk);
  endtask

  task automatic do_fall(input int low);
    step_clk = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic do_step(input int high, input int low);
    do_rise(high);
    do_fall(low);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    if (ph_w >= 0) exp_q_w.push_back(4'b0000);
    if (ph_h >= 0) exp_q_h.push_back(4'b0000);
    ph_w = -1;
    ph_h = -1;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (sem_w !== prev_w) begin
        if (exp_q_w.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wave_unexpected: got %b expected %b (no change due)", sem_w, prev_w);
        end else chk("wave_seq", sem_w, exp_q_w.pop_front());
        prev_w = sem_w;
      end
      if (sem_h !== prev_h) begin
        if (exp_q_h.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL half_unexpected: got %b expected %b (no change due)", sem_h, prev_h);
        end else chk("half_seq", sem_h, exp_q_h.pop_front());
        prev_h = sem_h;
      end
    end
  end

  initial begin
    // reset: 2 cycles with step_clk low, then 5 quiet cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_w", sem_w, 4'b0000);
    chk("reset_h", sem_h, 4'b0000);
    prev_w = sem_w;
    prev_h = sem_h;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold_w", sem_w, 4'b0000);
      chk("idle_hold_h", sem_h, 4'b0000);
    end

    // first step: exact three-edge latency, held high gives no more steps
    @(negedge clk);
    direction = 1'b0;
    step_clk = 1'b1;
    ph_w = next_phase(ph_w, 4, 1'b0);
    ph_h = next_phase(ph_h, 8, 1'b0);
    exp_q_w.push_back(wave_pat[ph_w]);
    exp_q_h.push_back(half_pat[ph_h]);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("latency_edge2_w", sem_w, 4'b0000);
    chk("latency_edge2_h", sem_h, 4'b0000);
    @(posedge clk);
    #1;
    chk("latency_edge3_w", sem_w, 4'b0001);
    chk("latency_edge3_h", sem_h, 4'b0001);
    repeat (6) @(negedge clk);
    chk("held_high_w", sem_w, 4'b0001);
    do_fall(4);

    // forward wrap, then reverse after reaching 0100
    do_reset(1);
    repeat (2) @(negedge clk);
    direction = 1'b0;
    repeat (7) do_step(4, 4);
    chk("fwd_end_w", sem_w, 4'b0100);
    direction = 1'b1;
    repeat (3) do_step(4, 4);
    chk("rev_end_w", sem_w, 4'b1000);

    // half-step full cycle and one reverse step
    do_reset(2);
    repeat (2) @(negedge clk);
    direction = 1'b0;
    repeat (9) do_step(4, 4);
    chk("half_wrap_h", sem_h, 4'b0001);
    direction = 1'b1;
    do_step(4, 4);
    chk("half_rev_h", sem_h, 4'b1001);

    // reset mid-run with step_clk held high through release
    do_reset(1);
    repeat (2) @(negedge clk);
    direction = 1'b0;
    repeat (3) do_step(4, 4);
    do_rise(4);
    chk("mid_state_h", sem_h, 4'b0110);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_after_rst_h", sem_h, 4'b0000);
      chk("held_after_rst_w", sem_w, 4'b0000);
    end
    do_fall(4);
    do_step(4, 4);
    chk("fresh_edge_h", sem_h, 4'b0001);

    // randomized steps, directions, widths and occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_reset($urandom_range(1, 3));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      direction = 1'($urandom_range(0, 1));
      do_step($urandom_range(3, 7), $urandom_range(3, 7));
    end

    // drain and report
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q_w.size() != 0) begin
      n_err++;
      $display("FAIL wave_drain: %0d pending, expected 0", exp_q_w.size());
    end
    n_cmp++;
    if (exp_q_h.size() != 0) begin
      n_err++;
      $display("FAIL half_drain: %0d pending, expected 0", exp_q_h.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
